// File: rtl/circ_frame_sequencer.sv
// rtl/circ_frame_sequencer.sv - CIRC frame assembler feeding the odd-symbol delay stage and C1 handoff
//
// Collects WORDS byte symbols following a frame sync into frame_q, pulses
// dly_en for one cycle to advance the one-frame delay line, then offers the
// delayed frame to C1 over c1_valid/c1_ready once the line holds a real
// previous frame.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   sym_d      in   incoming symbol
//   sym_valid  in   sym_d valid this cycle
//   sym_sync   in   frame sync, marks the cycle before the first symbol
//   frame_q    out  assembled frame, word i at [i*WIDTH +: WIDTH]
//   dly_en     out  one-cycle advance pulse to the delay stage
//   c1_valid   out  delayed frame available to C1
//   c1_ready   in   C1 accepts the frame
//   primed     out  delay line holds a real previous frame
//   frame_err  out  one-cycle pulse on short frame or overrun
//   overrun    out  sticky overrun flag, cleared only by reset
//   frame_cnt  out  frames handed to C1, wraps

module circ_frame_sequencer #(
   parameter int WIDTH = 8,
   parameter int WORDS = 32,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH-1:0]         sym_d,
   input  logic                     sym_valid,
   input  logic                     sym_sync,
   output logic [WORDS*WIDTH-1:0]   frame_q,
   output logic                     dly_en,
   output logic                     c1_valid,
   input  logic                     c1_ready,
   output logic                     primed,
   output logic                     frame_err,
   output logic                     overrun,
   output logic [CNT_W-1:0]         frame_cnt
);

   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_ADVANCE,
      S_HANDOFF
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [IDX_W-1:0] idx;
   logic             pending_sync;

   logic             wr_en;
   logic             idx_clr;
   logic             err_ev;
   logic             pend_set;
   logic             pend_clr;
   logic             primed_set;
   logic             primed_clr;
   logic             ovr_set;
   logic             cnt_inc;
   logic             last_word;
   logic             pend_eff;

   assign last_word = (idx == IDX_W'(WORDS - 1));
   // A sync arriving in the very cycle the busy phase ends still counts.
   assign pend_eff  = pending_sync | sym_sync;

   assign dly_en    = (state == S_ADVANCE);
   assign c1_valid  = (state == S_HANDOFF);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      wr_en      = 1'b0;
      idx_clr    = 1'b0;
      err_ev     = 1'b0;
      pend_set   = 1'b0;
      pend_clr   = 1'b0;
      primed_set = 1'b0;
      primed_clr = 1'b0;
      ovr_set    = 1'b0;
      cnt_inc    = 1'b0;

      case (state)
         S_IDLE: begin
            if (sym_sync) begin
               state_nx = S_COLLECT;
               idx_clr  = 1'b1;
               pend_clr = 1'b1;
            end
         end

         S_COLLECT: begin
            if (sym_valid && last_word) begin
               // Completing symbol wins over a coincident sync; the sync
               // is remembered for after the handoff.
               wr_en    = 1'b1;
               idx_clr  = 1'b1;
               pend_set = sym_sync;
               state_nx = S_ADVANCE;
            end else if (sym_sync) begin
               idx_clr = 1'b1;
               if (idx != '0) begin
                  err_ev     = 1'b1;
                  primed_clr = 1'b1;
               end
            end else if (sym_valid) begin
               wr_en = 1'b1;
            end
         end

         S_ADVANCE: begin
            err_ev   = sym_valid;
            ovr_set  = sym_valid;
            pend_set = sym_sync;
            if (primed) begin
               state_nx = S_HANDOFF;
            end else begin
               // First frame after reset/error only fills the delay line.
               primed_set = 1'b1;
               if (pend_eff) begin
                  state_nx = S_COLLECT;
                  idx_clr  = 1'b1;
                  pend_clr = 1'b1;
               end else begin
                  state_nx = S_IDLE;
               end
            end
         end

         S_HANDOFF: begin
            err_ev   = sym_valid;
            ovr_set  = sym_valid;
            pend_set = sym_sync;
            if (c1_ready) begin
               cnt_inc = 1'b1;
               if (pend_eff) begin
                  state_nx = S_COLLECT;
                  idx_clr  = 1'b1;
                  pend_clr = 1'b1;
               end else begin
                  state_nx = S_IDLE;
               end
            end
         end

         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_q      <= '0;
         idx          <= '0;
         pending_sync <= 1'b0;
         primed       <= 1'b0;
         frame_err    <= 1'b0;
         overrun      <= 1'b0;
         frame_cnt    <= '0;
      end else begin
         if (wr_en) begin
            frame_q[int'(idx)*WIDTH +: WIDTH] <= sym_d;
         end

         if (idx_clr) begin
            idx <= '0;
         end else if (wr_en) begin
            idx <= idx + IDX_W'(1);
         end

         if (pend_clr) begin
            pending_sync <= 1'b0;
         end else if (pend_set) begin
            pending_sync <= 1'b1;
         end

         if (primed_clr) begin
            primed <= 1'b0;
         end else if (primed_set) begin
            primed <= 1'b1;
         end

         frame_err <= err_ev;

         if (ovr_set) begin
            overrun <= 1'b1;
         end

         if (cnt_inc) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/circ_frame_sequencer.md
Name: circ_frame_sequencer

Overview:
- Assembles byte symbols from the EFM/sync front end into one CIRC frame of WORDS symbols.
- Drives the odd-symbol one-frame input delay stage: frame bus plus a one-cycle advance enable.
- Hands the delayed frame to the C1 decoder over a valid/ready handshake.
- Tracks delay-line priming, frame errors and frame count so downstream decoders never see stale odd symbols.

Parameters:
- WIDTH, 8, symbol width in bits.
- WORDS, 32, symbols per frame; even, ≥4.
- CNT_W, 16, width of the frame counter.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- SYM_D  in  WIDTH  incoming symbol.
- SYM_VALID  in  1  SYM_D valid this cycle.
- SYM_SYNC  in  1  frame sync; marks the cycle before the first symbol. Carries no data.
- FRAME_Q  out  WORDS*WIDTH  assembled frame to the delay stage D input; word i at bits [i*WIDTH +: WIDTH].
- DLY_EN  out  1  one-cycle advance pulse to the delay stage.
- C1_VALID  out  1  delayed frame available to C1.
- C1_READY  in  1  C1 accepts the frame.
- PRIMED  out  1  delay line holds a real previous frame.
- FRAME_ERR  out  1  one-cycle pulse on a short frame or overrun.
- OVERRUN  out  1  sticky; cleared only by reset.
- FRAME_CNT  out  CNT_W  frames handed to C1; wraps modulo 2^CNT_W.

Behaviour:
- Reset (RST_N low, async): state IDLE. FRAME_Q=0, symbol index=0, DLY_EN=0, C1_VALID=0, PRIMED=0, FRAME_ERR=0, OVERRUN=0, FRAME_CNT=0, pending_sync=0.
- Reset mid-frame or mid-handoff aborts immediately. The partial frame is discarded and no DLY_EN is issued.

State machine:
- IDLE: ignore SYM_VALID. SYM_SYNC → COLLECT with index=0.
- COLLECT:
  - SYM_VALID writes SYM_D into word[index], index++.
  - When the write lands in word WORDS-1 → ADVANCE.
  - SYM_SYNC with index<WORDS (and not completing the frame that cycle) is a short frame: FRAME_ERR pulse, PRIMED←0, index←0, stay in COLLECT.
  - SYM_SYNC and SYM_VALID in the same cycle: the symbol is dropped, sync wins (short-frame rule applies if index>0). A sync with index=0 just restarts, with no error.
- ADVANCE (exactly 1 cycle):
  - DLY_EN=1.
  - If PRIMED=1 → HANDOFF. Otherwise set PRIMED←1 and go to COLLECT if pending_sync, else IDLE. The first frame after reset or error is never offered to C1.
- HANDOFF:
  - C1_VALID=1, held until C1_READY sampled high.
  - On the ready cycle: C1_VALID←0, FRAME_CNT++. Then → COLLECT (index=0) if pending_sync, else IDLE.
  - C1_READY already high on HANDOFF entry completes in one cycle.
- Latency: last symbol accepted at edge N → DLY_EN high during N+1 → C1_VALID high from N+2.
- FRAME_Q:
  - Changes only on accepted symbol writes.
  - Stable through ADVANCE and HANDOFF.
  - Unwritten words keep their previous-frame value.

Busy / overrun (ADVANCE or HANDOFF):
- SYM_VALID: symbol dropped, FRAME_ERR pulse, OVERRUN←1.
- SYM_SYNC: sets pending_sync=1, no error.
- pending_sync is cleared on entry to COLLECT.

Other rules:
- A SYM_SYNC in the same cycle as the completing symbol write: the symbol completes the frame and the sync sets pending_sync.
- FRAME_ERR is never high for more than one cycle per event. Two events in one cycle give a single pulse.

Test Plan:
- Reset, SYNC, 32 symbols valued 0x00..0x1F → DLY_EN one cycle after the last symbol. No C1_VALID. PRIMED=1, FRAME_CNT=0, state IDLE.
- Second frame 0x20..0x3F, C1_READY held high → C1_VALID one cycle at N+2. FRAME_CNT=1. FRAME_Q word 5 = 0x25.
- C1_READY low for 10 cycles in HANDOFF → C1_VALID stays high, FRAME_Q unchanged. Ready pulse → C1_VALID drops next edge, FRAME_CNT increments once.
- SYNC after 17 symbols → FRAME_ERR one cycle, PRIMED=0. Next full frame produces DLY_EN but no C1_VALID.
- SYM_VALID and SYM_SYNC during HANDOFF → FRAME_ERR pulse, OVERRUN=1 sticky. After ready, state COLLECT directly with index 0, and a full frame completes normally.
- RST_N low for 1 cycle at symbol 20 of a primed frame → all outputs reset asynchronously. No DLY_EN. FRAME_CNT=0, PRIMED=0.
